// File: rtl/timer_pkg.sv
// Shared definitions for the alarm scheduler: timer control bit map,
// per-channel state encoding and the default count width.
package timer_pkg;

  localparam int COUNT_W_DEF     = 32;
  localparam int CTRL_W          = 8;
  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_RESET_BIT  = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } chan_state_e;

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: holds state, deadline, period and mode,
// performs the wrap-safe expiry test and the periodic reload.
module alarm_channel
  import timer_pkg::*;
#(
  parameter int COUNT_W = COUNT_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [COUNT_W-1:0] count_i,
  input  logic               req_hit_i,
  input  logic               req_cancel_i,
  input  logic               req_periodic_i,
  input  logic [COUNT_W-1:0] req_delay_i,
  output logic               armed_o,
  output logic               fire_o,
  output logic               overrun_o
);

  chan_state_e        state_q, state_d;
  logic [COUNT_W-1:0] deadline_q, deadline_d;
  logic [COUNT_W-1:0] period_q, period_d;
  logic               periodic_q, periodic_d;

  logic [COUNT_W-1:0] delay_sat;
  logic [COUNT_W-1:0] reload;
  logic               arm_req;
  logic               cancel_req;
  logic               expired;
  logic               fire;
  logic               reload_expired;

  // Deadline reached when (now - due) is non-negative as a signed value.
  function automatic logic reached(
    input logic [COUNT_W-1:0] now,
    input logic [COUNT_W-1:0] due
  );
    logic [COUNT_W-1:0] diff;
    diff = now - due;
    return !diff[COUNT_W-1];
  endfunction

  assign delay_sat = (req_delay_i == '0)
                   ? {{(COUNT_W-1){1'b0}}, 1'b1}
                   : req_delay_i;

  assign arm_req        = req_hit_i && !req_cancel_i;
  assign cancel_req     = req_hit_i && req_cancel_i;
  assign reload         = deadline_q + period_q;
  assign expired        = (state_q == ARMED)
                       && reached(count_i, deadline_q);
  assign fire           = expired && !req_hit_i;
  assign reload_expired = reached(count_i, reload);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      deadline_q <= '0;
      period_q   <= '0;
      periodic_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      deadline_q <= deadline_d;
      period_q   <= period_d;
      periodic_q <= periodic_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    deadline_d = deadline_q;
    period_d   = period_q;
    periodic_d = periodic_q;
    unique case (1'b1)
      cancel_req: begin
        state_d = IDLE;
      end
      arm_req: begin
        state_d    = ARMED;
        deadline_d = count_i + delay_sat;
        period_d   = delay_sat;
        periodic_d = req_periodic_i;
      end
      fire && periodic_q: begin
        deadline_d = reload;
      end
      fire && !periodic_q: begin
        state_d = IDLE;
      end
      default: ;
    endcase
  end

  always_comb begin
    armed_o   = (state_q == ARMED);
    fire_o    = fire;
    overrun_o = fire && periodic_q && reload_expired;
  end

endmodule

// File: rtl/timer_alarm_scheduler.sv
// Multiplexes one free-running timer across several alarm channels;
// decodes requests, keeps sticky status and drives the timer control.
module timer_alarm_scheduler
  import timer_pkg::*;
#(
  parameter  int NUM_CHANNELS = 4,
  parameter  int COUNT_W      = COUNT_W_DEF,
  localparam int IDX_W        = $clog2(NUM_CHANNELS)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [COUNT_W-1:0]      timer_count,
  output logic [CTRL_W-1:0]       timer_control,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [IDX_W-1:0]        req_chan,
  input  logic                    req_cancel,
  input  logic                    req_periodic,
  input  logic [COUNT_W-1:0]      req_delay,
  output logic [NUM_CHANNELS-1:0] alarm_pulse,
  output logic [NUM_CHANNELS-1:0] alarm_status,
  input  logic [NUM_CHANNELS-1:0] status_clear,
  output logic [NUM_CHANNELS-1:0] overrun
);

  logic                    ready_q;
  logic [CTRL_W-1:0]       ctrl_q, ctrl_d;
  logic [NUM_CHANNELS-1:0] pulse_q;
  logic [NUM_CHANNELS-1:0] status_q, status_d;
  logic [NUM_CHANNELS-1:0] overrun_q, overrun_d;

  logic                    xfer;
  logic                    any_armed;
  logic [NUM_CHANNELS-1:0] hit;
  logic [NUM_CHANNELS-1:0] armed;
  logic [NUM_CHANNELS-1:0] fire;
  logic [NUM_CHANNELS-1:0] ovr;

  assign xfer = req_valid && ready_q;

  // Indices at or beyond NUM_CHANNELS match no channel and are dropped.
  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
    assign hit[g] = xfer && (req_chan == IDX_W'(g));

    alarm_channel #(
      .COUNT_W (COUNT_W)
    ) u_chan (
      .clock          (clock),
      .reset          (reset),
      .count_i        (timer_count),
      .req_hit_i      (hit[g]),
      .req_cancel_i   (req_cancel),
      .req_periodic_i (req_periodic),
      .req_delay_i    (req_delay),
      .armed_o        (armed[g]),
      .fire_o         (fire[g]),
      .overrun_o      (ovr[g])
    );
  end

  assign any_armed = |armed;

  always_comb begin
    status_d  = (status_q & ~status_clear) | fire;
    overrun_d = (overrun_q & ~status_clear) | ovr;
    ctrl_d    = '0;
    ctrl_d[CTRL_ENABLE_BIT] = any_armed;
    ctrl_d[CTRL_RESET_BIT]  = ctrl_q[CTRL_ENABLE_BIT] && !any_armed;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ready_q   <= 1'b0;
      ctrl_q    <= CTRL_W'(1) << CTRL_RESET_BIT;
      pulse_q   <= '0;
      status_q  <= '0;
      overrun_q <= '0;
    end else begin
      ready_q   <= 1'b1;
      ctrl_q    <= ctrl_d;
      pulse_q   <= fire;
      status_q  <= status_d;
      overrun_q <= overrun_d;
    end
  end

  assign req_ready     = ready_q;
  assign timer_control = ctrl_q;
  assign alarm_pulse   = pulse_q;
  assign alarm_status  = status_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_timer_alarm_scheduler.sv
// Directed + randomized bench for timer_alarm_scheduler, checked
// against a per-channel deadline model kept in the bench.
module tb_timer_alarm_scheduler;

  localparam int N = 4;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] timer_count;
  logic [7:0]   timer_control;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_chan;
  logic         req_cancel;
  logic         req_periodic;
  logic [W-1:0] req_delay;
  logic [N-1:0] alarm_pulse;
  logic [N-1:0] alarm_status;
  logic [N-1:0] status_clear;
  logic [N-1:0] overrun;

  int tests = 0;
  int fails = 0;

  timer_alarm_scheduler #(
    .NUM_CHANNELS (N),
    .COUNT_W      (W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .timer_count   (timer_count),
    .timer_control (timer_control),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_chan      (req_chan),
    .req_cancel    (req_cancel),
    .req_periodic  (req_periodic),
    .req_delay     (req_delay),
    .alarm_pulse   (alarm_pulse),
    .alarm_status  (alarm_status),
    .status_clear  (status_clear),
    .overrun       (overrun)
  );

  always #5 clock = ~clock;

  // Reference model state
  bit         m_armed [N];
  bit [W-1:0] m_dl    [N];
  bit [W-1:0] m_per   [N];
  bit         m_perd  [N];
  bit [N-1:0] m_pulse;
  bit [N-1:0] m_status;
  bit [N-1:0] m_ovr;
  bit [7:0]   m_ctrl;
  bit         m_ready;

  function automatic bit due(input bit [W-1:0] now, input bit [W-1:0] dl);
    bit [W-1:0] d;
    d = now - dl;
    return (d[W-1] == 1'b0);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit any_now;
    bit xfer;
    bit [N-1:0] pul;
    bit [N-1:0] ov;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_armed[i] = 0; m_dl[i] = 0; m_per[i] = 0; m_perd[i] = 0;
      end
      m_pulse = 0; m_status = 0; m_ovr = 0;
      m_ctrl = 8'h02; m_ready = 0;
      return;
    end
    any_now = 0;
    for (int i = 0; i < N; i++) any_now |= m_armed[i];
    xfer = req_valid && m_ready;
    pul = 0;
    ov = 0;
    for (int i = 0; i < N; i++) begin
      if (xfer && int'(req_chan) == i) begin
        if (req_cancel) m_armed[i] = 0;
        else begin
          m_armed[i] = 1;
          m_per[i] = (req_delay == 0) ? 1 : req_delay;
          m_dl[i] = timer_count + m_per[i];
          m_perd[i] = req_periodic;
        end
      end else if (m_armed[i] && due(timer_count, m_dl[i])) begin
        pul[i] = 1;
        if (m_perd[i]) begin
          m_dl[i] = m_dl[i] + m_per[i];
          if (due(timer_count, m_dl[i])) ov[i] = 1;
        end else m_armed[i] = 0;
      end
    end
    m_pulse = pul;
    m_status = (m_status & ~status_clear) | pul;
    m_ovr = (m_ovr & ~status_clear) | ov;
    m_ctrl = {6'b0, m_ctrl[0] && !any_now, any_now};
    m_ready = 1;
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    #1;
    check("pulse", 32'(alarm_pulse), 32'(m_pulse));
    check("status", 32'(alarm_status), 32'(m_status));
    check("overrun", 32'(overrun), 32'(m_ovr));
    check("ctrl", 32'(timer_control), 32'(m_ctrl));
    check("ready", 32'(req_ready), 32'(m_ready));
  endtask

  task automatic req(input int ch, input bit cancel, input bit per,
                     input logic [W-1:0] dly);
    req_valid = 1;
    req_chan = 2'(ch);
    req_cancel = cancel;
    req_periodic = per;
    req_delay = dly;
    cycle();
    req_valid = 0;
  endtask

  task automatic tick(input logic [W-1:0] c);
    timer_count = c;
    cycle();
  endtask

  initial begin
    int npulse;
    reset = 1; timer_count = 0; req_valid = 0; req_chan = 0;
    req_cancel = 0; req_periodic = 0; req_delay = 0; status_clear = 0;
    m_ctrl = 0; m_ready = 0; m_pulse = 0; m_status = 0; m_ovr = 0;
    repeat (3) cycle();
    check("reset_ctrl", 32'(timer_control), 32'h02);
    check("reset_ready", 32'(req_ready), 32'h0);
    reset = 0;
    cycle();
    check("post_reset_ctrl", 32'(timer_control), 32'h00);
    check("post_reset_ready", 32'(req_ready), 32'h1);

    // One-shot ch0, delay 5 at count 100
    timer_count = 100;
    req(0, 0, 0, 5);
    npulse = 0;
    for (int c = 101; c <= 110; c++) begin
      tick(W'(c));
      if (alarm_pulse[0]) npulse++;
      if (c == 105) check("oneshot_pulse", 32'(alarm_pulse), 32'h1);
    end
    check("oneshot_count", npulse, 1);
    check("oneshot_status", 32'(alarm_status), 32'h1);
    check("oneshot_ctrl_idle", 32'(timer_control), 32'h00);

    // Periodic ch1, delay 3 at count 10, cancel at 17
    timer_count = 10;
    req(1, 0, 1, 3);
    npulse = 0;
    for (int c = 11; c <= 22; c++) begin
      timer_count = W'(c);
      if (c == 17) req(1, 1, 0, 0);
      else cycle();
      if (alarm_pulse[1]) npulse++;
    end
    check("periodic_count", npulse, 2);
    check("periodic_ovr", 32'(overrun), 32'h0);

    // Wrap: arm ch2 at FFFF_FFFE, delay 4
    timer_count = 32'hFFFF_FFFE;
    req(2, 0, 0, 4);
    tick(32'hFFFF_FFFF);
    check("wrap_early_a", 32'(alarm_pulse), 32'h0);
    tick(32'h0);
    tick(32'h1);
    check("wrap_early_b", 32'(alarm_pulse), 32'h0);
    tick(32'h2);
    check("wrap_fire", 32'(alarm_pulse), 32'h4);
    tick(32'h3);

    status_clear = 4'hF;
    cycle();
    status_clear = 0;

    // Simultaneous ch0 / ch3
    timer_count = 200;
    req(0, 0, 0, 6);
    timer_count = 201;
    req(3, 0, 0, 5);
    for (int c = 202; c <= 207; c++) begin
      tick(W'(c));
      if (c == 206) check("dual_pulse", 32'(alarm_pulse), 32'h9);
    end
    status_clear = 4'b0001;
    cycle();
    status_clear = 0;
    check("dual_clear", 32'(alarm_status), 32'h8);

    // Periodic period 1 with count jumps -> overrun
    timer_count = 300;
    req(1, 0, 1, 1);
    tick(303);
    check("ovr_first", 32'(overrun[1]), 32'h1);
    tick(306);
    repeat (5) tick(306);
    check("ovr_sticky", 32'(overrun[1]), 32'h1);
    req(1, 1, 0, 0);
    status_clear = 4'hF;
    cycle();
    status_clear = 0;

    // Reset while armed
    timer_count = 400;
    req(0, 0, 0, 10);
    req(1, 0, 1, 20);
    reset = 1;
    cycle();
    check("rst_armed_ctrl", 32'(timer_control), 32'h02);
    check("rst_armed_pulse", 32'(alarm_pulse), 32'h0);
    reset = 0;
    npulse = 0;
    for (int c = 402; c <= 430; c++) begin
      tick(W'(c));
      if (alarm_pulse != 0) npulse++;
    end
    check("rst_no_pulse", npulse, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if (i == 300) timer_count = 32'hFFFF_FFF0;
      else timer_count = timer_count + W'($urandom_range(0, 3));
      req_valid = ($urandom_range(0, 1) == 1);
      req_chan = 2'($urandom_range(0, 3));
      req_cancel = ($urandom_range(0, 3) == 0);
      req_periodic = ($urandom_range(0, 1) == 1);
      req_delay = W'($urandom_range(0, 8));
      status_clear = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      if (i % 97 == 50) reset = 1;
      cycle();
      reset = 0;
    end
    req_valid = 0;
    status_clear = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
